// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, block constants and the small-sigma helpers used by
// both the message scheduler and the round stage.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int BLOCK_WORDS = 16;
    localparam int SCHED_WORDS = 64;

    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_EXPAND = 1'b1
    } sched_state_e;

    function automatic word_t ror32(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t sigma0(input word_t x);
        return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_word.sv
// Combinational next-schedule-word generator:
// W[t+16] = sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t].
module sha256_msg_word
    import sha256_pkg::*;
(
    input  logic [31:0] i_w0,
    input  logic [31:0] i_w1,
    input  logic [31:0] i_w9,
    input  logic [31:0] i_w14,
    output logic [31:0] o_new
);

    word_t w_s0;
    word_t w_s1;

    assign w_s0  = sigma0(i_w1);
    assign w_s1  = sigma1(i_w14);
    assign o_new = w_s1 + i_w9 + w_s0 + i_w0;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads 16 words, then streams W0..W63
// from a sliding 16-word window, one word per output handshake.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        busy
);

    localparam logic [5:0] LAST_LOAD  = 6'(BLOCK_WORDS - 1);
    localparam logic [5:0] LAST_SCHED = 6'(SCHED_WORDS - 1);

    sched_state_e r_state;
    logic [5:0]   r_cnt;
    word_t        r_win [BLOCK_WORDS];

    sched_state_e w_state_nxt;
    logic [5:0]   w_cnt_nxt;
    logic         w_shift;
    word_t        w_shift_data;
    word_t        w_new;

    sha256_msg_word u_msg_word (
        .i_w0  (r_win[0]),
        .i_w1  (r_win[1]),
        .i_w9  (r_win[9]),
        .i_w14 (r_win[14]),
        .o_new (w_new)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift      = 1'b0;
        w_shift_data = in_word;
        case (r_state)
            ST_LOAD: begin
                if (in_valid) begin
                    w_shift = 1'b1;
                    if (r_cnt == LAST_LOAD) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_EXPAND;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            ST_EXPAND: begin
                // The word generated on the final handshake is never observed;
                // the next load overwrites the whole window anyway.
                w_shift_data = w_new;
                if (out_ready) begin
                    w_shift = 1'b1;
                    if (r_cnt == LAST_SCHED) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_shift) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[BLOCK_WORDS-1] <= w_shift_data;
        end
    end

    // Index and word are gated to zero while loading so idle outputs are clean.
    assign in_ready  = (r_state == ST_LOAD);
    assign out_valid = (r_state == ST_EXPAND);
    assign busy      = (r_state == ST_EXPAND);
    assign out_word  = (r_state == ST_EXPAND) ? r_win[0] : '0;
    assign out_idx   = (r_state == ST_EXPAND) ? r_cnt : '0;

endmodule
